// File: rtl/cdb_arbiter.sv
// cdb_arbiter: CDB writeback arbiter with one-entry result slot per unit; `define CDB_RR_EN for round-robin, else fixed priority (lowest index wins)
module cdb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    input  logic [NUM_FU-1:0]        fu_regwrite,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic                     cdb_regwrite,
    output logic [NUM_FU-1:0]        cdb_grant
);
    logic [NUM_FU-1:0] held;
    logic [NUM_FU-1:0] accept;
    logic [TAG_W-1:0]  tag_q  [NUM_FU];
    logic [DATA_W-1:0] data_q [NUM_FU];
    logic [NUM_FU-1:0] rw_q;

    assign fu_ready  = {NUM_FU{~flush}} & (~held | cdb_grant);
    assign accept    = fu_valid & fu_ready;
    assign cdb_valid = |held;

`ifdef CDB_RR_EN
    localparam int PW = NUM_FU > 1 ? $clog2(NUM_FU) : 1;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gidx;

    // scan candidates backwards from the furthest so the one nearest rr_ptr is written last and wins
    always_comb begin
        cdb_grant = '0;
        gidx      = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (held[(int'(rr_ptr) + k) % NUM_FU]) begin
                cdb_grant = '0;
                cdb_grant[(int'(rr_ptr) + k) % NUM_FU] = 1'b1;
                gidx = PW'((int'(rr_ptr) + k) % NUM_FU);
            end
        end
    end

    // move the pointer just past the winner; idle and flush cycles leave it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (cdb_valid && !flush)
            rr_ptr <= (gidx == PW'(NUM_FU - 1)) ? '0 : gidx + PW'(1);
    end
`else
    // fixed priority: scan downwards so the lowest held index is written last and wins
    always_comb begin
        cdb_grant = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (held[k]) begin
                cdb_grant    = '0;
                cdb_grant[k] = 1'b1;
            end
        end
    end
`endif

    // occupancy: a new accept beats the drain of the granted slot, flush empties everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            held <= '0;
        else
            held <= flush ? '0 : accept | (held & ~cdb_grant);
    end

    // payload capture; contents are meaningless while the slot is not held, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                tag_q[i]  <= fu_tag[i*TAG_W +: TAG_W];
                data_q[i] <= fu_data[i*DATA_W +: DATA_W];
                rw_q[i]   <= fu_regwrite[i];
            end
        end
    end

    // broadcast mux; an empty grant vector leaves the bus at zero
    always_comb begin
        cdb_tag      = '0;
        cdb_data     = '0;
        cdb_regwrite = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (cdb_grant[i]) begin
                cdb_tag      = tag_q[i];
                cdb_data     = data_q[i];
                cdb_regwrite = rw_q[i];
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed checks of cdb_arbiter against a slot-level reference model
module tb_cdb_arbiter;
    localparam int N  = 5;
    localparam int TW = 4;
    localparam int DW = 32;
`ifdef CDB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [N-1:0]    fu_valid = '0;
    logic [N-1:0]    fu_ready;
    logic [N*TW-1:0] fu_tag = '0;
    logic [N*DW-1:0] fu_data = '0;
    logic [N-1:0]    fu_regwrite = '0;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic            cdb_regwrite;
    logic [N-1:0]    cdb_grant;

    cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_tag(fu_tag), .fu_data(fu_data), .fu_regwrite(fu_regwrite),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_regwrite(cdb_regwrite), .cdb_grant(cdb_grant)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit            m_held [N];
    logic [TW-1:0] m_tag  [N];
    logic [DW-1:0] m_data [N];
    bit            m_rw   [N];
    int            m_ptr;
    logic [N-1:0]  last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            int j = RR ? (m_ptr + k) % N : k;
            if (m_held[j]) return j;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_held[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic drive(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d, input bit rw);
        fu_valid[u] = 1'b1;
        fu_tag[u*TW +: TW] = t;
        fu_data[u*DW +: DW] = d;
        fu_regwrite[u] = rw;
    endtask

    // called at posedge+1 with inputs set; checks the cycle, advances the model, returns at next posedge+1
    task automatic step(input string nm);
        int g;
        logic [N-1:0] eg, er;
        g  = m_winner();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        for (int i = 0; i < N; i++) er[i] = !flush && (!m_held[i] || g == i);
        #1;
        check({nm, ".valid"}, 64'(cdb_valid), 64'(g >= 0));
        check({nm, ".grant"}, 64'(cdb_grant), 64'(eg));
        check({nm, ".tag"}, 64'(cdb_tag), g >= 0 ? 64'(m_tag[g]) : 64'(0));
        check({nm, ".data"}, 64'(cdb_data), g >= 0 ? 64'(m_data[g]) : 64'(0));
        check({nm, ".rw"}, 64'(cdb_regwrite), g >= 0 ? 64'(m_rw[g]) : 64'(0));
        check({nm, ".ready"}, 64'(fu_ready), 64'(er));
        last_acc = fu_valid & er;
        for (int i = 0; i < N; i++) begin
            if (flush) m_held[i] = 1'b0;
            else if (last_acc[i]) begin
                m_held[i] = 1'b1;
                m_tag[i]  = fu_tag[i*TW +: TW];
                m_data[i] = fu_data[i*DW +: DW];
                m_rw[i]   = fu_regwrite[i];
            end else if (g == i) m_held[i] = 1'b0;
        end
        if (g >= 0 && !flush) m_ptr = (g + 1) % N;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_reset();
        #2;
        check("rst.valid", 64'(cdb_valid), 64'(0));
        check("rst.ready", 64'(fu_ready), 64'h1f);
        check("rst.grant", 64'(cdb_grant), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single result from ALU
        drive(0, 4'h3, 32'hDEADBEEF, 1'b1);
        step("single_in");
        fu_valid = '0;
        check("single.tag", 64'(cdb_tag), 64'h3);
        check("single.data", 64'(cdb_data), 64'hDEADBEEF);
        check("single.grant", 64'(cdb_grant), 64'h1);
        step("single_out");
        step("single_idle");

        // MUL streams tags 1,2,3 back to back
        for (int t = 1; t <= 3; t++) begin
            drive(1, TW'(t), 32'h100 + DW'(t), 1'b1);
            step("stream");
            check("stream.tag", 64'(cdb_tag), 64'(t));
        end
        fu_valid = '0;
        step("stream_end");
        step("stream_idle");

        // all five contend at once
        for (int u = 0; u < N; u++) drive(u, TW'(u + 8), DW'(u) * 32'h1111, u[0]);
        step("cont_in");
        fu_valid = '0;
        for (int c = 0; c < N; c++) step("cont");
        step("cont_idle");

        // flush with slots 2 and 4 held while ALU offers a result
        drive(2, 4'h2, 32'h22, 1'b1);
        drive(4, 4'h4, 32'h44, 1'b0);
        step("flush_load");
        fu_valid = '0;
        drive(0, 4'h9, 32'h99, 1'b1);
        flush = 1'b1;
        step("flush");
        flush = 1'b0;
        fu_valid = '0;
        step("flush_after");

        // ALU and DIV continuously refilled
        for (int c = 0; c < 6; c++) begin
            drive(0, TW'(c), DW'(c), 1'b1);
            drive(2, TW'(c + 6), DW'(c) + 32'h200, 1'b0);
            step("prio");
        end
        fu_valid = '0;
        for (int c = 0; c < 8; c++) step("prio_drain");

        // randomized traffic with handshake-respecting units and occasional flush
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_acc[i]) fu_valid[i] = 1'b0;
                if (!fu_valid[i] && $urandom_range(1, 0) == 1)
                    drive(i, TW'($urandom), $urandom, 1'($urandom));
            end
            flush = ($urandom_range(19, 0) == 0);
            step("rand");
        end
        flush = 1'b0;
        fu_valid = '0;
        for (int c = 0; c < 8; c++) step("rand_drain");

        // asynchronous reset mid-operation with slots 1 and 3 held
        drive(1, 4'h1, 32'h11, 1'b1);
        drive(3, 4'h3, 32'h33, 1'b1);
        step("mid_load");
        fu_valid = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check("mid.valid", 64'(cdb_valid), 64'(0));
        check("mid.ready", 64'(fu_ready), 64'h1f);
        check("mid.grant", 64'(cdb_grant), 64'(0));
        m_reset();
        @(posedge clk);
        #1;
        check("mid.ready_hold", 64'(fu_ready), 64'h1f);
        check("mid.valid_hold", 64'(cdb_valid), 64'(0));
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) step("mid_after");
        drive(4, 4'hA, 32'hAAAA, 1'b1);
        step("post_rst_in");
        fu_valid = '0;
        step("post_rst_out");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
